flit_injector: RTL and testbench

FLIT_INJECTOR -- requirements
Module: flit_injector

---
 rtl/flit_injector_pkg.sv | 14 +
 rtl/flit_fifo.sv | 56 +++++
 rtl/flit_injector.sv | 106 ++++++++++
 tb/tb_flit_injector.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_injector_pkg.sv
// Shared framing definitions for the flit injector.
package flit_injector_pkg;

  typedef enum logic [1:0] {
    HEADER  = 2'd0,
    SIZE    = 2'd1,
    PAYLOAD = 2'd2
  } frame_state_t;

  // Position of the address and length flits within a packet.
  localparam int HEADER_IDX = 0;
  localparam int SIZE_IDX   = 1;

endpackage

// File: rtl/flit_fifo.sv
// Flit buffer: circular storage with wrapping pointers and an occupancy counter.
module flit_fifo
  import flit_injector_pkg::*;
#(
  parameter int FLIT_SIZE    = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [FLIT_SIZE-1:0] data,
  output logic [FLIT_SIZE-1:0] head,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(BUFFER_DEPTH);
  localparam int CW = AW + 1;

  logic [FLIT_SIZE-1:0] mem [BUFFER_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CW'(BUFFER_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/flit_injector.sv
// Flit injector: buffers producer flits, emits them under credit, frames packets.
//
// state   | meaning
// HEADER  | next output flit is a packet's target address
// SIZE    | next output flit is the payload length N
// PAYLOAD | remaining payload flits still to be emitted
module flit_injector
  import flit_injector_pkg::*;
#(
  parameter int FLIT_SIZE    = 32,
  parameter int BUFFER_DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 src_valid_i,
  output logic                 src_ready_o,
  input  logic [FLIT_SIZE-1:0] src_data_i,
  input  logic                 eoa_i,
  output logic                 tx_o,
  input  logic                 credit_i,
  output logic [FLIT_SIZE-1:0] data_o,
  output logic                 eoa_o,
  output logic [15:0]          pkt_sent_o
);

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  frame_state_t         state;
  frame_state_t         state_next;
  logic [FLIT_SIZE-1:0] remaining;
  logic [FLIT_SIZE-1:0] remaining_next;
  logic                 pkt_done;

  assign src_ready_o = ~full;
  assign tx_o        = ~empty;
  assign push        = src_valid_i & src_ready_o;
  assign pop         = tx_o & credit_i;

  flit_fifo #(
    .FLIT_SIZE    (FLIT_SIZE),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .data  (src_data_i),
    .head  (data_o),
    .full  (full),
    .empty (empty)
  );

  // Framing state, payload counter, packet counter and end-of-application flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= HEADER;
      remaining  <= '0;
      pkt_sent_o <= '0;
      eoa_o      <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      if (pkt_done) pkt_sent_o <= pkt_sent_o + 16'd1;
      eoa_o     <= eoa_i & empty & (state == HEADER);
    end
  end

  // Next framing state, advanced only on output transfers.
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    pkt_done       = 1'b0;
    case (state)
      HEADER: begin
        if (pop) state_next = SIZE;
      end
      SIZE: begin
        if (pop) begin
          if (data_o != '0) begin
            state_next     = PAYLOAD;
            remaining_next = data_o;
          end else begin
            state_next = HEADER;
            pkt_done   = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (pop) begin
          remaining_next = remaining - FLIT_SIZE'(1);
          if (remaining == FLIT_SIZE'(1)) begin
            state_next = HEADER;
            pkt_done   = 1'b1;
          end
        end
      end
      default: begin
        state_next     = HEADER;
        remaining_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector with hand-computed expectations.
module tb_flit_injector;
  import flit_injector_pkg::*;

  localparam int W = 32;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          src_valid;
  logic          src_ready;
  logic [W-1:0]  src_data;
  logic          eoa_in;
  logic          tx;
  logic          credit;
  logic [W-1:0]  data_out;
  logic          eoa_out;
  logic [15:0]   pkt_sent;

  int n_total = 0;
  int n_bad   = 0;

  flit_injector #(.FLIT_SIZE(W), .BUFFER_DEPTH(D)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .src_data_i  (src_data),
    .eoa_i       (eoa_in),
    .tx_o        (tx),
    .credit_i    (credit),
    .data_o      (data_out),
    .eoa_o       (eoa_out),
    .pkt_sent_o  (pkt_sent)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    src_valid = 1'b0;
    credit    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [W-1:0] p1 [4];
  logic [W-1:0] zp [5];
  int           zcnt [5];
  logic [W-1:0] ep [5];
  logic [W-1:0] rp [6];
  logic [W-1:0] np [3];
  logic [W-1:0] rx [$];
  logic [W-1:0] prev_data;
  bit           prev_stall;
  int           pushed;

  initial begin
    p1[HEADER_IDX] = 32'h0101; p1[SIZE_IDX] = 32'd2; p1[2] = 32'hA; p1[3] = 32'hB;
    zp[0] = 32'h0203; zp[1] = 32'd0; zp[2] = 32'h0000; zp[3] = 32'd1; zp[4] = 32'h5;
    zcnt[0] = 0; zcnt[1] = 0; zcnt[2] = 1; zcnt[3] = 1; zcnt[4] = 1;
    ep[0] = 32'h0404; ep[1] = 32'd3; ep[2] = 32'hA1; ep[3] = 32'hA2; ep[4] = 32'hA3;
    rp[0] = 32'h0606; rp[1] = 32'd4; rp[2] = 32'hB1; rp[3] = 32'hB2; rp[4] = 32'hB3; rp[5] = 32'hB4;
    np[0] = 32'h0707; np[1] = 32'd1; np[2] = 32'hC1;
    src_data = '0;
    eoa_in   = 1'b0;
    do_reset();

    check_val("rst_tx", {31'd0, tx}, 32'd0);
    check_val("rst_ready", {31'd0, src_ready}, 32'd1);
    check_val("rst_pkt", {16'd0, pkt_sent}, 32'd0);
    check_val("rst_eoa", {31'd0, eoa_out}, 32'd0);

    // Single packet with credit always available.
    credit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      src_valid = 1'b1;
      src_data  = p1[k];
      tick();
      check_val("s1_tx", {31'd0, tx}, 32'd1);
      check_val("s1_data", data_out, p1[k]);
      check_val("s1_pkt_pending", {16'd0, pkt_sent}, 32'd0);
    end
    src_valid = 1'b0;
    tick();
    check_val("s1_pkt_done", {16'd0, pkt_sent}, 32'd1);
    check_val("s1_drained", {31'd0, tx}, 32'd0);

    // Backpressure: credit pattern 1,0,0,1 repeating.
    pushed     = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 12; c++) begin
      credit = ((c % 4) == 0) || ((c % 4) == 3);
      if (pushed < 4) begin
        src_valid = 1'b1;
        src_data  = p1[pushed];
      end else begin
        src_valid = 1'b0;
      end
      if (prev_stall) begin
        check_val("bp_hold_data", data_out, prev_data);
        check_val("bp_hold_tx", {31'd0, tx}, 32'd1);
      end
      if (tx && credit) rx.push_back(data_out);
      prev_stall = tx && !credit;
      prev_data  = data_out;
      if (src_valid && src_ready) pushed++;
      tick();
    end
    src_valid = 1'b0;
    check_val("bp_count", rx.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < rx.size()) check_val("bp_order", rx[k], p1[k]);
    end
    check_val("bp_pkt", {16'd0, pkt_sent}, 32'd2);

    // Full FIFO: fill with credit withheld, then a refused push during a pop.
    credit = 1'b0;
    for (int k = 0; k < 8; k++) begin
      src_valid = 1'b1;
      src_data  = 32'h300 + k;
      check_val("full_fill_ready", {31'd0, src_ready}, 32'd1);
      tick();
    end
    check_val("full_ready", {31'd0, src_ready}, 32'd0);
    check_val("full_head", data_out, 32'h300);
    src_data = 32'h308;
    tick();
    check_val("full_refused", {31'd0, src_ready}, 32'd0);
    credit = 1'b1;
    tick();
    credit = 1'b0;
    check_val("full_reopen", {31'd0, src_ready}, 32'd1);
    check_val("full_head2", data_out, 32'h301);
    tick();
    check_val("full_again", {31'd0, src_ready}, 32'd0);
    src_valid = 1'b0;
    credit    = 1'b1;
    for (int k = 1; k < 9; k++) begin
      check_val("full_drain", data_out, 32'h300 + k);
      tick();
    end
    check_val("full_empty", {31'd0, tx}, 32'd0);
    do_reset();
    check_val("full_rst_pkt", {16'd0, pkt_sent}, 32'd0);

    // Zero-length packet followed by a one-flit payload packet.
    credit = 1'b1;
    for (int k = 0; k < 5; k++) begin
      src_valid = 1'b1;
      src_data  = zp[k];
      tick();
      check_val("zl_data", data_out, zp[k]);
      check_val("zl_pkt", {16'd0, pkt_sent}, zcnt[k]);
    end
    src_valid = 1'b0;
    tick();
    check_val("zl_pkt_final", {16'd0, pkt_sent}, 32'd2);

    // End of application raised while a payload drains.
    credit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      src_valid = 1'b1;
      src_data  = ep[k];
      tick();
    end
    src_valid = 1'b0;
    credit    = 1'b1;
    tick();
    tick();
    eoa_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_val("eoa_inflight", {31'd0, eoa_out}, 32'd0);
      tick();
    end
    check_val("eoa_last_edge", {31'd0, eoa_out}, 32'd0);
    check_val("eoa_pkt", {16'd0, pkt_sent}, 32'd3);
    credit = 1'b0;
    tick();
    check_val("eoa_set", {31'd0, eoa_out}, 32'd1);
    src_valid = 1'b1;
    src_data  = 32'h0505;
    tick();
    src_valid = 1'b0;
    tick();
    check_val("eoa_drop", {31'd0, eoa_out}, 32'd0);
    check_val("eoa_push_tx", {31'd0, tx}, 32'd1);
    eoa_in = 1'b0;
    do_reset();

    // Reset in the middle of a packet, then a clean packet.
    credit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      src_valid = 1'b1;
      src_data  = rp[k];
      tick();
    end
    src_valid = 1'b0;
    credit    = 1'b1;
    tick();
    tick();
    check_val("mid_payload_head", data_out, 32'hB1);
    do_reset();
    check_val("mid_rst_tx", {31'd0, tx}, 32'd0);
    check_val("mid_rst_pkt", {16'd0, pkt_sent}, 32'd0);
    check_val("mid_rst_ready", {31'd0, src_ready}, 32'd1);
    credit = 1'b1;
    for (int k = 0; k < 3; k++) begin
      src_valid = 1'b1;
      src_data  = np[k];
      tick();
      check_val("mid_new_data", data_out, np[k]);
    end
    src_valid = 1'b0;
    tick();
    check_val("mid_new_pkt", {16'd0, pkt_sent}, 32'd1);
    check_val("mid_new_drained", {31'd0, tx}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
